// File: rtl/csr_timer_intr_pkg.sv
// -----------------------------------------------------------------------------
// csr_timer_intr_pkg
// Shared definitions for the timer / interrupt-source stage that feeds the
// CSR/exception block.
//   - CSR addresses decoded by this stage (ESTAT, TID, TCFG, TVAL, TICLR)
//   - ESTAT.IS bit positions (SWI, HWI, TI, IPI)
//   - Timer state enum
//   - highest_onehot(): fixed-priority picker used for the interrupt vector
// -----------------------------------------------------------------------------
package csr_timer_intr_pkg;

    localparam logic [13:0] CSR_ESTAT = 14'h005;
    localparam logic [13:0] CSR_TID   = 14'h040;
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;  // read-only, never decoded for writes
    localparam logic [13:0] CSR_TICLR = 14'h044;

    localparam int IS_W    = 13;
    localparam int IS_SWI0 = 0;   // [1:0]  software interrupts
    localparam int IS_HWI0 = 2;   // [9:2]  hardware interrupts
    localparam int IS_TI   = 11;  // timer interrupt
    localparam int IS_IPI  = 12;  // inter-processor interrupt

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } timer_state_e;

    // One-hot of the most significant set bit; bit 12 has the highest priority.
    function automatic logic [IS_W-1:0] highest_onehot(input logic [IS_W-1:0] req);
        logic [IS_W-1:0] sel;
        sel = '0;
        for (int i = 0; i < IS_W; i++) begin
            if (req[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/csr_timer_intr_if.sv
// -----------------------------------------------------------------------------
// csr_timer_intr_if
// CSR write bus from the commit stage.
//   csr_we    : write strobe
//   csr_num   : CSR address being written
//   csr_wdata : write data (already masked by the writer)
// Modports: master (commit stage drives), slave (CSR consumer).
// -----------------------------------------------------------------------------
interface csr_timer_intr_if;

    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata;

    modport master (output csr_we, output csr_num, output csr_wdata);
    modport slave  (input  csr_we, input  csr_num, input  csr_wdata);

endinterface

// File: rtl/csr_timer_core.sv
// -----------------------------------------------------------------------------
// csr_timer_core
// Countdown timer owning TCFG, TVAL and the TI pending bit.
//   clk, reset  : clock, synchronous active-high reset
//   tcfg_we_i   : TCFG write strobe (address already decoded)
//   ticlr_we_i  : TICLR write strobe (address already decoded)
//   wdata_i     : CSR write data
//   tcfg_o      : TCFG value
//   tval_o      : current countdown value
//   ti_o        : timer interrupt pending (ESTAT.IS[11])
// TCFG layout: [0] enable, [1] periodic, [TIMER_W-1:2] InitVal.
// -----------------------------------------------------------------------------
module csr_timer_core
    import csr_timer_intr_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tcfg_we_i,
    input  logic               ticlr_we_i,
    input  logic [31:0]        wdata_i,
    output logic [TIMER_W-1:0] tcfg_o,
    output logic [TIMER_W-1:0] tval_o,
    output logic               ti_o
);

    timer_state_e       state_q, state_d;
    logic [TIMER_W-1:0] tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] tval_q, tval_d;
    logic               ti_q, ti_d;
    logic [TIMER_W-1:0] reload_val;
    logic               expire;

    assign reload_val = {tcfg_q[TIMER_W-1:2], 2'b00};

    // A TCFG write in the expiry cycle takes precedence, so that cycle does
    // not count as an expiry.
    assign expire = (state_q == T_RUN) && (tval_q == '0) && !tcfg_we_i;

    // State register.
    // NOTE: every clocked assignment is non-blocking so all registers update
    // from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= T_IDLE;
            tcfg_q  <= '0;
            tval_q  <= '0;
            ti_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tcfg_q  <= tcfg_d;
            tval_q  <= tval_d;
            ti_q    <= ti_d;
        end
    end

    // Next-state logic.
    // NOTE: each combinational output gets a default first so no path leaves
    // it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        if (tcfg_we_i) begin
            state_d = wdata_i[0] ? T_RUN : T_IDLE;
        end else if (expire && !tcfg_q[1]) begin
            state_d = T_IDLE;
        end
    end

    // Datapath / output logic.
    always_comb begin
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        ti_d   = ti_q;

        if (ticlr_we_i && wdata_i[0]) begin
            ti_d = 1'b0;
        end

        if (tcfg_we_i) begin
            tcfg_d = wdata_i[TIMER_W-1:0];
            tval_d = {wdata_i[TIMER_W-1:2], 2'b00};
        end else if (expire) begin
            // Placed after the TICLR clear so a same-cycle set wins.
            ti_d = 1'b1;
            if (tcfg_q[1]) begin
                tval_d = reload_val;
            end else begin
                tcfg_d[0] = 1'b0;
            end
        end else if (state_q == T_RUN) begin
            tval_d = tval_q - TIMER_W'(1);
        end
    end

    assign tcfg_o = tcfg_q;
    assign tval_o = tval_q;
    assign ti_o   = ti_q;

endmodule

// File: rtl/csr_timer_intr.sv
// -----------------------------------------------------------------------------
// csr_timer_intr
// Interrupt-source stage upstream of the CSR/exception block. Owns TID, the
// timer (via csr_timer_core), the 64-bit stable counter and ESTAT.IS[12:0],
// and produces the prioritised one-hot interrupt vector plus a registered
// interrupt request.
//   clk, reset : clock, synchronous active-high reset
//   csr_bus    : CSR write bus (csr_we / csr_num / csr_wdata), slave side
//   hw_int     : level hardware interrupt lines -> ESTAT.IS[9:2]
//   ipi_int    : inter-processor interrupt level -> ESTAT.IS[12]
//   ecfg_lie   : per-source local enables
//   crmd_ie    : global interrupt enable
//   estat_is   : ESTAT[12:0]
//   tid, tcfg, tval, cnt : timer CSRs and stable counter
//   int_vec    : one-hot highest-priority pending & enabled source
//   int_req    : registered interrupt request
// Build option HWI_SYNC_EN: adds a 2-flop synchroniser in front of the
// HWI/IPI sampling register (3-cycle input-to-estat_is latency instead of 1).
// -----------------------------------------------------------------------------
module csr_timer_intr
    import csr_timer_intr_pkg::*;
#(
    parameter int          TIMER_W = 32,
    parameter logic [31:0] TID_RST = 32'h0
) (
    input  logic                clk,
    input  logic                reset,
    csr_timer_intr_if.slave     csr_bus,
    input  logic [7:0]          hw_int,
    input  logic                ipi_int,
    input  logic [IS_W-1:0]     ecfg_lie,
    input  logic                crmd_ie,
    output logic [IS_W-1:0]     estat_is,
    output logic [31:0]         tid,
    output logic [TIMER_W-1:0]  tcfg,
    output logic [TIMER_W-1:0]  tval,
    output logic [63:0]         cnt,
    output logic [IS_W-1:0]     int_vec,
    output logic                int_req
);

    logic            wr_estat, wr_tid, wr_tcfg, wr_ticlr;
    logic [1:0]      swi_q, swi_d;
    logic [7:0]      hwi_q;
    logic            ipi_q;
    logic [31:0]     tid_q, tid_d;
    logic [63:0]     cnt_q, cnt_d;
    logic            int_req_q, int_req_d;
    logic            ti;
    logic [7:0]      hw_src;
    logic            ipi_src;
    logic [IS_W-1:0] pend;

    assign wr_estat = csr_bus.csr_we && (csr_bus.csr_num == CSR_ESTAT);
    assign wr_tid   = csr_bus.csr_we && (csr_bus.csr_num == CSR_TID);
    assign wr_tcfg  = csr_bus.csr_we && (csr_bus.csr_num == CSR_TCFG);
    assign wr_ticlr = csr_bus.csr_we && (csr_bus.csr_num == CSR_TICLR);

    csr_timer_core #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .tcfg_we_i  (wr_tcfg),
        .ticlr_we_i (wr_ticlr),
        .wdata_i    (csr_bus.csr_wdata),
        .tcfg_o     (tcfg),
        .tval_o     (tval),
        .ti_o       (ti)
    );

`ifdef HWI_SYNC_EN
    logic [7:0] hw_meta_q, hw_sync_q;
    logic       ipi_meta_q, ipi_sync_q;

    // Two-flop synchroniser for asynchronous interrupt lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            hw_meta_q  <= '0;
            hw_sync_q  <= '0;
            ipi_meta_q <= 1'b0;
            ipi_sync_q <= 1'b0;
        end else begin
            hw_meta_q  <= hw_int;
            hw_sync_q  <= hw_meta_q;
            ipi_meta_q <= ipi_int;
            ipi_sync_q <= ipi_meta_q;
        end
    end

    assign hw_src  = hw_sync_q;
    assign ipi_src = ipi_sync_q;
`else
    assign hw_src  = hw_int;
    assign ipi_src = ipi_int;
`endif

    always_comb begin
        swi_d     = wr_estat ? csr_bus.csr_wdata[1:0] : swi_q;
        tid_d     = wr_tid ? csr_bus.csr_wdata : tid_q;
        cnt_d     = cnt_q + 64'd1;
        int_req_d = crmd_ie && (|pend);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            swi_q     <= '0;
            hwi_q     <= '0;
            ipi_q     <= 1'b0;
            tid_q     <= TID_RST;
            cnt_q     <= '0;
            int_req_q <= 1'b0;
        end else begin
            swi_q     <= swi_d;
            hwi_q     <= hw_src;
            ipi_q     <= ipi_src;
            tid_q     <= tid_d;
            cnt_q     <= cnt_d;
            int_req_q <= int_req_d;
        end
    end

    // ESTAT.IS assembly; bit 10 is reserved and reads as zero.
    always_comb begin
        estat_is                  = '0;
        estat_is[IS_SWI0 +: 2]    = swi_q;
        estat_is[IS_HWI0 +: 8]    = hwi_q;
        estat_is[IS_TI]           = ti;
        estat_is[IS_IPI]          = ipi_q;
    end

    assign pend    = estat_is & ecfg_lie;
    assign int_vec = highest_onehot(pend);
    assign int_req = int_req_q;
    assign tid     = tid_q;
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_csr_timer_intr.sv
`timescale 1ns/1ps
module tb_csr_timer_intr;
    import csr_timer_intr_pkg::*;

    localparam int          TIMER_W = 32;
    localparam logic [31:0] TID_RST = 32'h1234_5678;
`ifdef HWI_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  hw_int;
    logic        ipi_int;
    logic [12:0] ecfg_lie;
    logic        crmd_ie;
    logic [12:0] estat_is;
    logic [31:0] tid;
    logic [31:0] tcfg;
    logic [31:0] tval;
    logic [63:0] cnt;
    logic [12:0] int_vec;
    logic        int_req;

    csr_timer_intr_if bus();

    csr_timer_intr #(
        .TIMER_W (TIMER_W),
        .TID_RST (TID_RST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .csr_bus  (bus),
        .hw_int   (hw_int),
        .ipi_int  (ipi_int),
        .ecfg_lie (ecfg_lie),
        .crmd_ie  (crmd_ie),
        .estat_is (estat_is),
        .tid      (tid),
        .tcfg     (tcfg),
        .tval     (tval),
        .cnt      (cnt),
        .int_vec  (int_vec),
        .int_req  (int_req)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [63:0] m_cnt;
    logic [31:0] m_tcfg, m_tval, m_tid;
    logic        m_ti, m_req;
    logic [1:0]  m_swi;
    logic [8:0]  m_pipe[$];  // {ipi, hw} samples in flight; [0] is what ESTAT shows

    function automatic logic [12:0] m_estat();
        logic [8:0] vis;
        vis = (m_pipe.size() > 0) ? m_pipe[0] : 9'h0;
        return {vis[8], m_ti, 1'b0, vis[7:0], m_swi};
    endfunction

    function automatic logic [12:0] m_vec(input logic [12:0] pend);
        logic [12:0] r;
        r = '0;
        for (int i = 12; i >= 0; i--) begin
            if (pend[i] && r == '0) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Advances DUT and model by one rising edge using the inputs applied now.
    task automatic tick();
        logic [63:0] n_cnt;
        logic [31:0] n_tcfg, n_tval, n_tid, wd;
        logic        n_ti, n_req;
        logic [1:0]  n_swi;
        logic [8:0]  n_pipe[$];
        logic        we;
        wd = bus.csr_wdata;
        we = bus.csr_we;
        if (reset) begin
            n_cnt = 0; n_tcfg = 0; n_tval = 0; n_ti = 0; n_swi = 0; n_tid = TID_RST; n_req = 0;
            n_pipe.delete();
            repeat (LAT) n_pipe.push_back(9'h0);
        end else begin
            n_cnt  = m_cnt + 1;
            n_req  = crmd_ie && ((m_estat() & ecfg_lie) != 0);
            n_swi  = (we && bus.csr_num == CSR_ESTAT) ? wd[1:0] : m_swi;
            n_tid  = (we && bus.csr_num == CSR_TID) ? wd : m_tid;
            n_tcfg = m_tcfg;
            n_tval = m_tval;
            n_ti   = m_ti;
            if (we && bus.csr_num == CSR_TICLR && wd[0]) n_ti = 0;
            if (we && bus.csr_num == CSR_TCFG) begin
                n_tcfg = wd;
                n_tval = wd & ~32'h3;
            end else if (m_tcfg[0]) begin
                if (m_tval > 0) n_tval = m_tval - 1;
                else begin
                    n_ti = 1;
                    if (m_tcfg[1]) n_tval = m_tcfg & ~32'h3;
                    else n_tcfg = m_tcfg & ~32'h1;
                end
            end
            n_pipe = m_pipe;
            n_pipe.push_back({ipi_int, hw_int});
            void'(n_pipe.pop_front());
        end
        @(posedge clk);
        #1;
        m_cnt = n_cnt; m_tcfg = n_tcfg; m_tval = n_tval; m_ti = n_ti;
        m_swi = n_swi; m_tid = n_tid; m_req = n_req; m_pipe = n_pipe;
    endtask

    task automatic check_model(input int cyc);
        check($sformatf("rnd%0d estat", cyc), estat_is, m_estat());
        check($sformatf("rnd%0d tid", cyc), tid, m_tid);
        check($sformatf("rnd%0d tcfg", cyc), tcfg, m_tcfg);
        check($sformatf("rnd%0d tval", cyc), tval, m_tval);
        check($sformatf("rnd%0d cnt", cyc), cnt, m_cnt);
        check($sformatf("rnd%0d int_vec", cyc), int_vec, m_vec(m_estat() & ecfg_lie));
        check($sformatf("rnd%0d int_req", cyc), int_req, m_req);
    endtask

    task automatic csr_write(input logic [13:0] num, input logic [31:0] data);
        bus.csr_we    = 1'b1;
        bus.csr_num   = num;
        bus.csr_wdata = data;
        tick();
        bus.csr_we    = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [13:0] num;
        logic [31:0] wdata;
        logic [7:0]  hw;
        logic        ipi;
        logic [12:0] lie;
        logic        ie;
        logic [12:0] exp_estat;
        logic [12:0] exp_vec;
        logic        exp_req;
        logic [31:0] exp_tid;
        logic [31:0] exp_tval;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, CSR_ESTAT, 32'h3,         8'h01, 1'b0, 13'h1FFF, 1'b1, 13'h0007, 13'h0004, 1'b1, TID_RST, 32'h0};
        tbl[1]  = '{1'b0, CSR_ESTAT, 32'h0,         8'h01, 1'b1, 13'h1FFF, 1'b1, 13'h1007, 13'h1000, 1'b1, TID_RST, 32'h0};
        tbl[2]  = '{1'b0, CSR_ESTAT, 32'h0,         8'h01, 1'b1, 13'h0003, 1'b1, 13'h1007, 13'h0002, 1'b1, TID_RST, 32'h0};
        tbl[3]  = '{1'b0, CSR_ESTAT, 32'h0,         8'h01, 1'b1, 13'h0000, 1'b1, 13'h1007, 13'h0000, 1'b0, TID_RST, 32'h0};
        tbl[4]  = '{1'b0, CSR_ESTAT, 32'h0,         8'h01, 1'b1, 13'h1FFF, 1'b0, 13'h1007, 13'h1000, 1'b0, TID_RST, 32'h0};
        tbl[5]  = '{1'b1, CSR_ESTAT, 32'h0,         8'h80, 1'b0, 13'h1FFF, 1'b1, 13'h0200, 13'h0200, 1'b1, TID_RST, 32'h0};
        tbl[6]  = '{1'b1, CSR_TVAL,  32'hFFFF_FFFF, 8'h00, 1'b0, 13'h1FFF, 1'b1, 13'h0000, 13'h0000, 1'b0, TID_RST, 32'h0};
        tbl[7]  = '{1'b1, CSR_ESTAT, 32'hFFFF_FFFE, 8'hFF, 1'b0, 13'h0002, 1'b1, 13'h03FE, 13'h0002, 1'b1, TID_RST, 32'h0};
        tbl[8]  = '{1'b1, CSR_TID,   32'hDEAD_BEEF, 8'h00, 1'b0, 13'h1FFF, 1'b1, 13'h0002, 13'h0002, 1'b1, 32'hDEAD_BEEF, 32'h0};
        tbl[9]  = '{1'b1, CSR_ESTAT, 32'h0,         8'h00, 1'b0, 13'h1FFF, 1'b1, 13'h0000, 13'h0000, 1'b0, 32'hDEAD_BEEF, 32'h0};
        tbl[10] = '{1'b1, 14'h3FFF,  32'hFFFF_FFFF, 8'h00, 1'b0, 13'h1FFF, 1'b1, 13'h0000, 13'h0000, 1'b0, 32'hDEAD_BEEF, 32'h0};
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; hw_int = '0; ipi_int = 1'b0; ecfg_lie = '0; crmd_ie = 1'b0;
        bus.csr_we = 1'b0; bus.csr_num = '0; bus.csr_wdata = '0;
        m_pipe.delete();
        m_cnt = 0; m_tcfg = 0; m_tval = 0; m_tid = TID_RST; m_ti = 0; m_req = 0; m_swi = 0;

        // Reset state, then 10 idle cycles.
        tick(); tick();
        check("rst cnt", cnt, 64'd0);
        check("rst estat", estat_is, 13'h0);
        check("rst int_req", int_req, 1'b0);
        check("rst tid", tid, TID_RST);
        check("rst tcfg", tcfg, 32'h0);
        check("rst tval", tval, 32'h0);
        reset = 1'b0;
        repeat (10) tick();
        check("idle cnt", cnt, 64'd10);
        check("idle estat", estat_is, 13'h0);
        check("idle int_req", int_req, 1'b0);
        check("idle tid", tid, TID_RST);

        // One-shot, InitVal 4.
        csr_write(CSR_TCFG, 32'h0000_0011);
        check("os load tval", tval, 32'd16);
        check("os load tcfg", tcfg, 32'h11);
        for (int k = 15; k >= 0; k--) begin
            tick();
            check($sformatf("os tval%0d", k), tval, k);
            check($sformatf("os noti%0d", k), estat_is[IS_TI], 1'b0);
        end
        tick();
        check("os ti set", estat_is[IS_TI], 1'b1);
        check("os tval hold", tval, 32'h0);
        check("os tcfg en clr", tcfg, 32'h10);
        repeat (3) tick();
        check("os ti stays", estat_is[IS_TI], 1'b1);
        csr_write(CSR_TICLR, 32'h0);
        check("ticlr0 no effect", estat_is[IS_TI], 1'b1);
        csr_write(CSR_TICLR, 32'h1);
        check("ticlr1 clears", estat_is[IS_TI], 1'b0);
        repeat (20) tick();
        check("os no 2nd ti", estat_is[IS_TI], 1'b0);
        check("os tval still 0", tval, 32'h0);

        // Periodic, InitVal 2: expiry every 9 cycles.
        csr_write(CSR_TCFG, 32'h0000_000B);
        check("per load", tval, 32'd8);
        repeat (8) tick();
        check("per tval0", tval, 32'd0);
        check("per no ti yet", estat_is[IS_TI], 1'b0);
        tick();
        check("per ti1", estat_is[IS_TI], 1'b1);
        check("per reload", tval, 32'd8);
        csr_write(CSR_TICLR, 32'h1);
        check("per clr", estat_is[IS_TI], 1'b0);
        check("per tval7", tval, 32'd7);
        repeat (7) tick();
        check("per tval0 b", tval, 32'd0);
        check("per ti0 b", estat_is[IS_TI], 1'b0);
        csr_write(CSR_TICLR, 32'h1);
        check("set beats clr", estat_is[IS_TI], 1'b1);
        check("per reload b", tval, 32'd8);
        csr_write(CSR_TICLR, 32'h1);
        check("per clr b", estat_is[IS_TI], 1'b0);
        repeat (7) tick();
        check("per tval0 c", tval, 32'd0);
        csr_write(CSR_TCFG, 32'h0000_0015);
        check("write beats expiry ti", estat_is[IS_TI], 1'b0);
        check("write beats expiry tval", tval, 32'd20);
        check("write beats expiry tcfg", tcfg, 32'h15);
        csr_write(CSR_TCFG, 32'h0);
        check("timer off", tval, 32'h0);

        // Table: each row applied, then held until everything has settled.
        for (int i = 0; i < 11; i++) begin
            hw_int = tbl[i].hw; ipi_int = tbl[i].ipi; ecfg_lie = tbl[i].lie; crmd_ie = tbl[i].ie;
            bus.csr_we = tbl[i].we; bus.csr_num = tbl[i].num; bus.csr_wdata = tbl[i].wdata;
            tick();
            bus.csr_we = 1'b0;
            repeat (LAT) tick();
            check($sformatf("tbl%0d estat", i), estat_is, tbl[i].exp_estat);
            check($sformatf("tbl%0d int_vec", i), int_vec, tbl[i].exp_vec);
            check($sformatf("tbl%0d int_req", i), int_req, tbl[i].exp_req);
            check($sformatf("tbl%0d tid", i), tid, tbl[i].exp_tid);
            check($sformatf("tbl%0d tval", i), tval, tbl[i].exp_tval);
        end

        // int_req lags pend by exactly one cycle.
        hw_int = '0; ipi_int = 1'b0; ecfg_lie = 13'h1FFF; crmd_ie = 1'b1;
        csr_write(CSR_ESTAT, 32'h1);
        check("lat estat", estat_is, 13'h1);
        check("lat req0", int_req, 1'b0);
        tick();
        check("lat req1", int_req, 1'b1);
        csr_write(CSR_ESTAT, 32'h0);
        check("lat fall still1", int_req, 1'b1);
        tick();
        check("lat fall 0", int_req, 1'b0);

        // TI pending, LIE[11] set, global enable off.
        ecfg_lie = 13'h0800; crmd_ie = 1'b0;
        csr_write(CSR_TCFG, 32'h0000_0001);
        tick();
        check("ti pend", estat_is[IS_TI], 1'b1);
        check("ie0 vec", int_vec, 13'h0800);
        tick();
        check("ie0 req", int_req, 1'b0);
        crmd_ie = 1'b1;
        tick();
        check("ie1 req", int_req, 1'b1);
        csr_write(CSR_TICLR, 32'h1);
        ecfg_lie = '0;

        // Reset in the middle of a countdown.
        hw_int = 8'h01; ecfg_lie = 13'h1FFF; crmd_ie = 1'b1;
        csr_write(CSR_TCFG, 32'h0000_0009);
        repeat (3) tick();
        check("mid tval5", tval, 32'd5);
        check("mid req1", int_req, 1'b1);
        reset = 1'b1;
        tick();
        check("mid rst tval", tval, 32'h0);
        check("mid rst ti", estat_is[IS_TI], 1'b0);
        check("mid rst req", int_req, 1'b0);
        check("mid rst estat", estat_is, 13'h0);
        check("mid rst tcfg", tcfg, 32'h0);
        check("mid rst cnt", cnt, 64'd0);
        reset = 1'b0; hw_int = '0;
        repeat (LAT + 1) tick();

        // Single-cycle hw_int pulse travels through the sampling path.
        hw_int = 8'h01;
        tick();
        hw_int = '0;
        for (int t = 1; t <= LAT + 1; t++) begin
            if (t > 1) tick();
            check($sformatf("pulse t%0d", t), estat_is[IS_HWI0], (t == LAT) ? 1'b1 : 1'b0);
        end

        // Randomised run against the model.
        for (int c = 0; c < 3000; c++) begin
            int sel;
            reset    = ($urandom_range(0, 99) == 0);
            hw_int   = $urandom_range(0, 3) == 0 ? 8'($urandom) : hw_int;
            ipi_int  = $urandom_range(0, 7) == 0 ? ~ipi_int : ipi_int;
            ecfg_lie = $urandom_range(0, 15) == 0 ? 13'($urandom) : ecfg_lie;
            crmd_ie  = $urandom_range(0, 15) == 0 ? ~crmd_ie : crmd_ie;
            bus.csr_we = ($urandom_range(0, 9) < 3);
            sel = $urandom_range(0, 5);
            case (sel)
                0: bus.csr_num = CSR_ESTAT;
                1: bus.csr_num = CSR_TID;
                2: bus.csr_num = CSR_TCFG;
                3: bus.csr_num = CSR_TVAL;
                4: bus.csr_num = CSR_TICLR;
                default: bus.csr_num = 14'($urandom);
            endcase
            bus.csr_wdata = (sel == 2) ? (($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3)))
                                       : $urandom;
            tick();
            check_model(c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
